// File: rtl/dram_model.sv
// dram_model: behavioural line-wide main memory with a fixed access latency.
// Latency: ack pulses in the cycle after edge N+delay, where N is the accept edge.
// Backpressure: one request in flight; cs is ignored until the FSM returns to IDLE.
// Ports:
//   clk    - rising-edge clock
//   rst_i  - asynchronous active-low reset; aborts any in-flight request
//   addr_i - byte address; low log2(data_width/8) bits ignored
//   data_i - write line data
//   cs     - request valid
//   we     - 1 = write, 0 = read, sampled with cs
//   ack    - one-cycle completion pulse
//   data_o - read line data, held until the next read completes
module dram_model #(
    parameter int data_width = 256,
    parameter int mem_size   = 2048,
    parameter int delay      = 10,
    parameter int addr_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic [addr_width-1:0] addr_i,
    input  logic [data_width-1:0] data_i,
    input  logic                  cs,
    input  logic                  we,
    output logic                  ack,
    output logic [data_width-1:0] data_o
);

    localparam int OFF_W  = $clog2(data_width / 8);
    localparam int IDX_W  = addr_width - OFF_W;
    localparam int MEM_AW = (mem_size > 1) ? $clog2(mem_size) : 1;
    localparam int CNT_W  = $clog2(delay + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Plain array so benches can preload and inspect it hierarchically.
    reg [data_width-1:0] memory [0:mem_size-1];

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   counter;
    logic [IDX_W-1:0]   idx_q;
    logic [data_width-1:0] data_q;
    logic               we_q;
    logic               in_range;
    logic [MEM_AW-1:0]  mem_idx;

    // Byte-offset bits within a line carry no information for this model.
    logic unused_offset;
    assign unused_offset = ^addr_i[OFF_W-1:0];

    assign in_range = (idx_q < IDX_W'(mem_size));
    assign mem_idx  = idx_q[MEM_AW-1:0];

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE is the last cycle of the request: the access and the ack are
    // registered at the edge that leaves DONE (edge N+delay), so the FSM is
    // already back in IDLE while ack is high and can accept at N+delay+1.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cs) begin
                    state_nxt = (delay == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (counter == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            counter <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ack     <= 1'b0;
            data_o  <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs) begin
                        idx_q   <= addr_i[addr_width-1:OFF_W];
                        data_q  <= data_i;
                        we_q    <= we;
                        counter <= CNT_W'(delay - 1);
                    end
                end
                BUSY: begin
                    counter <= counter - CNT_W'(1);
                end
                DONE: begin
                    ack <= 1'b1;
                    if (!we_q) begin
                        data_o <= in_range ? memory[mem_idx] : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory is never cleared by reset; the rst_i gate keeps an aborted
    // write from landing if reset coincides with the completing edge.
    always_ff @(posedge clk) begin
        if (rst_i && state == DONE && we_q && in_range) begin
            memory[mem_idx] <= data_q;
        end
    end

endmodule

// File: tb/tb_dram_model.sv
// tb_dram_model: directed bench for dram_model with default parameters.
// Latency: each access expected to ack 10 edges after the accept edge.
// Backpressure: requests are issued one at a time, waiting on ack with a bound.
module tb_dram_model;

    logic         clk;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         cs;
    logic         we;
    logic         ack;
    logic [255:0] data_o;

    int tests;
    int fails;

    dram_model dut (
        .clk    (clk),
        .rst_i  (rst_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .cs     (cs),
        .we     (we),
        .ack    (ack),
        .data_o (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request: cs for a single accept edge, then the request inputs are
    // scrambled to prove the DUT works from latched values. Returns the
    // number of edges from accept to the edge that raised ack (-1 on timeout).
    task automatic acc(input logic w, input logic [31:0] a, input logic [255:0] d, output int lat);
        cs     = 1'b1;
        we     = w;
        addr_i = a;
        data_i = d;
        tick();
        cs     = 1'b0;
        we     = ~w;
        addr_i = 32'hFFFF_FFFF;
        data_i = '1;
        lat    = 0;
        while (!ack && lat < 30) begin
            tick();
            lat++;
        end
        if (!ack) lat = -1;
    endtask

    int   lat;
    logic seen;

    initial begin
        tests  = 0;
        fails  = 0;
        rst_i  = 1'b0;
        cs     = 1'b0;
        we     = 1'b0;
        addr_i = '0;
        data_i = '0;

        dut.memory[0]    = 256'h5;
        dut.memory[2]    = 256'h22;
        dut.memory[32]   = 256'h0;
        dut.memory[2047] = 256'h0;

        // Requests during reset are ignored.
        tick();
        cs = 1'b1;
        repeat (3) tick();
        check("rst_ack", 256'(ack), 256'd0);
        check("rst_data_o", data_o, 256'd0);
        cs = 1'b0;
        tick();
        check("rst_ack_after_cs", 256'(ack), 256'd0);
        rst_i = 1'b1;
        tick();

        // Read latency from preloaded line 0.
        acc(1'b0, 32'h0, 256'h0, lat);
        check("rd0_lat", 256'(lat), 256'd10);
        check("rd0_data", data_o, 256'h5);
        tick();
        check("rd0_ack_one_cycle", 256'(ack), 256'd0);

        // Write then read line 32.
        acc(1'b1, 32'h400, 256'hDEAD, lat);
        check("wr32_lat", 256'(lat), 256'd10);
        tick();
        check("wr32_mem", dut.memory[32], 256'hDEAD);
        check("wr32_data_o_held", data_o, 256'h5);
        acc(1'b0, 32'h400, 256'h0, lat);
        check("rd32_lat", 256'(lat), 256'd10);
        check("rd32_data", data_o, 256'hDEAD);
        tick();

        // Last line in range.
        acc(1'b1, 32'h0000_FFE0, 256'hCAFE, lat);
        check("wr2047_lat", 256'(lat), 256'd10);
        tick();
        check("wr2047_mem", dut.memory[2047], 256'hCAFE);
        acc(1'b0, 32'h0000_FFE0, 256'h0, lat);
        check("rd2047_data", data_o, 256'hCAFE);
        tick();

        // First line out of range: acked, write dropped, read returns 0.
        acc(1'b1, 32'h0001_0000, 256'hBEEF, lat);
        check("wr2048_lat", 256'(lat), 256'd10);
        tick();
        check("wr2048_no_alias", dut.memory[0], 256'h5);
        acc(1'b0, 32'h0001_0000, 256'h0, lat);
        check("rd2048_lat", 256'(lat), 256'd10);
        check("rd2048_data", data_o, 256'd0);
        tick();

        // Low byte-offset bits are ignored: 0x41 is line 2.
        acc(1'b0, 32'h41, 256'h0, lat);
        check("rd_off_data", data_o, 256'h22);
        tick();

        // cs held high through completion: second accept at N+11.
        cs     = 1'b1;
        we     = 1'b0;
        addr_i = 32'h0;
        tick();
        lat = 0;
        while (!ack && lat < 30) begin
            tick();
            lat++;
        end
        check("cs_held_first_lat", 256'(lat), 256'd10);
        lat = 0;
        tick();
        lat++;
        while (!ack && lat < 30) begin
            tick();
            lat++;
        end
        cs = 1'b0;
        check("cs_held_second_lat", 256'(lat), 256'd11);
        tick();

        // Reset in the middle of a write aborts it.
        cs     = 1'b1;
        we     = 1'b1;
        addr_i = 32'h400;
        data_i = 256'h1234;
        tick();
        cs = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | ack;
        end
        check("abort_no_ack", 256'(seen), 256'd0);
        check("abort_mem", dut.memory[32], 256'hDEAD);
        check("abort_data_o", data_o, 256'd0);
        rst_i = 1'b1;
        tick();
        acc(1'b0, 32'h400, 256'h0, lat);
        check("post_rst_lat", 256'(lat), 256'd10);
        check("post_rst_data", data_o, 256'hDEAD);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
